pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Sequences the 50 MHz to 100 MHz system PLL and gates the Nios/display reset. Runs on the free-running 50 MHz reference clock, drives the PLL's active-high reset, and qualifies its lock output. Releases the system reset only after lock has been stable for a programmed time. Retries failed lock attempts and re-sequences on loss of lock, with a sticky fault state and a loss-of-lock counter for the Nios status register.

## Interface
- RST_HOLD_CYCLES, 100: cycles pll_rst is held high per attempt (2 us at 50 MHz); must be ≥1.
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK before the attempt fails (1 ms); must be ≥1.
- LOCK_STABLE_CYCLES, 1000: consecutive synchronized-lock cycles required before release; must be ≥1.
- MAX_RETRIES, 3: extra attempts after the first timeout before FAULT; range 0..15.
- CNT_W, 16: width of the shared cycle counter; must hold the largest parameter minus 1.

Ports:
- clk  in  1  50 MHz reference clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL locked; asynchronous to clk.
- restart_req  in  1  single-cycle soft re-initialisation request, synchronous to clk.
- pll_rst  out  1  active-high PLL reset.
- sys_reset_n  out  1  active-low system reset; the consumer re-synchronizes it into the 100 MHz domain.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  timeouts in the current bring-up.
- lock_loss_cnt  out  8  losses of lock while in RUN; saturates at 255.

## Operation
- pll_locked passes through a 2-FF synchronizer; lock_s is the second flop. Only lock_s is used.
- States:
  - RESET_PLL: pll_rst=1.
  - WAIT_LOCK: pll_rst=0.
  - STABLE: pll_rst=0.
  - RUN: pll_rst=0, sys_reset_n=1, ready=1.
  - FAULT: pll_rst=1, fault=1.
- sys_reset_n=0 in every state except RUN.
- The cycle counter clears on every state entry.
- RESET_PLL → WAIT_LOCK when cnt == RST_HOLD_CYCLES-1.
- WAIT_LOCK:
  - lock_s=1 → STABLE.
  - Otherwise, at cnt == LOCK_TIMEOUT_CYCLES-1:
    - if retry_cnt < MAX_RETRIES: retry_cnt++, → RESET_PLL;
    - else → FAULT.
- STABLE:
  - lock_s=0 → WAIT_LOCK, with a fresh timeout and no retry increment.
  - cnt == LOCK_STABLE_CYCLES-1 with lock_s=1 → RUN, retry_cnt cleared.
- RUN: lock_s=0 → RESET_PLL, lock_loss_cnt++ (saturating).
- FAULT: exited only by restart_req or reset_n.
- restart_req in any state → RESET_PLL, retry_cnt cleared, lock_loss_cnt kept. It has priority over every other transition in the same cycle.
- When a restart_req and a RUN lock loss occur in the same cycle, lock_loss_cnt still increments.

## Timing
- Reset values (asynchronous, immediate):
  - state = RESET_PLL;
  - pll_rst = 1, sys_reset_n = 0, ready = 0, fault = 0;
  - retry_cnt = 0, lock_loss_cnt = 0;
  - synchronizer flops = 0.
- All outputs are registered and change on the same edge as the state register. There are no combinational paths from inputs to outputs.
- pll_rst is high for exactly RST_HOLD_CYCLES cycles per RESET_PLL entry, counted from the reset_n deassertion edge or from the entry edge.
- Lock qualification latency: lock_s rises 2 edges after the first edge sampling pll_locked=1. STABLE is entered 1 edge later. sys_reset_n rises LOCK_STABLE_CYCLES edges after that, i.e. LOCK_STABLE_CYCLES+3 edges after first sampling.
- Loss of lock in RUN: sys_reset_n falls and pll_rst rises 3 edges after the first edge sampling pll_locked=0.
- Lock-loss glitches shorter than one clk period may be missed. This is accepted.
- reset_n asserted mid-operation forces the reset values immediately, independent of clk.

## Test plan
Common parameters: RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2.
1. Normal bring-up, pll_locked rising 5 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_reset_n/ready rise 11 edges after pll_locked is first sampled; retry_cnt=0.
2. pll_locked drops for 3 cycles mid-STABLE → return to WAIT_LOCK, no retry increment; sys_reset_n rises 11 edges after lock re-asserts.
3. pll_locked held 0 → three 4-cycle pll_rst pulses separated by 20-cycle waits, retry_cnt reaching 2, then fault=1, pll_rst=1, sys_reset_n=0, held indefinitely.
4. In RUN, pll_locked drops → sys_reset_n=0 and pll_rst=1 3 edges later, lock_loss_cnt 0→1. Repeat 300 times → lock_loss_cnt saturates at 255.
5. restart_req in FAULT, and separately in RUN with a simultaneous lock loss → RESET_PLL next edge with fault=0 and retry_cnt=0; lock_loss_cnt preserved in the first case and incremented in the second.
6. reset_n pulsed low mid-STABLE, between clk edges → all outputs take their reset values immediately, lock_loss_cnt=0; a full normal bring-up follows.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer
//
// Brings up the 50 MHz -> 100 MHz system PLL and holds the Nios/display
// system reset until the PLL lock has been stable for a programmed time.
// A failed lock attempt is retried a limited number of times before the
// block parks in a sticky FAULT state. A loss of lock while running
// re-sequences the PLL and is counted for the Nios status register.
//
// Ports:
//   clk           in   50 MHz free-running reference clock (only clock)
//   reset_n       in   asynchronous active-low reset
//   pll_locked    in   PLL lock indication, asynchronous to clk
//   restart_req   in   single-cycle soft re-initialisation request
//   pll_rst       out  active-high PLL reset
//   sys_reset_n   out  active-low system reset (re-synchronized by consumer)
//   ready         out  high only while running with a qualified lock
//   fault         out  high only in the sticky fault state
//   retry_cnt     out  lock timeouts seen during the current bring-up
//   lock_loss_cnt out  losses of lock while running, saturating at 255
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 100,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    // Terminal counts, compared against the shared cycle counter
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_nxt;
    logic             loss_event;
    logic             lock_meta;
    logic             lock_s;

    // Two-flop synchronizer for the asynchronous lock signal. Only the
    // second flop (lock_s) is allowed to steer the state machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state decision. A restart request overrides every other
    // transition, but a lock loss in RUN during the same cycle is still
    // counted, so loss_event is decided independently of the restart.
    always_comb begin
        state_nxt  = state;
        retry_nxt  = retry_cnt;
        loss_event = (state == ST_RUN) && !lock_s;

        if (restart_req) begin
            state_nxt = ST_RESET_PLL;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_nxt = retry_cnt + 4'd1;
                            state_nxt = ST_RESET_PLL;
                        end else begin
                            state_nxt = ST_FAULT;
                        end
                    end
                end
                ST_STABLE: begin
                    // A dropout here restarts the lock wait with a fresh
                    // timeout but is not treated as a failed attempt.
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        retry_nxt = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_RESET_PLL;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_RESET_PLL;
                end
            endcase
        end
    end

    // State, counters and outputs. Outputs are decoded from the next state
    // so that they are registered yet change on the same edge as the state.
    // The counter clears on every state entry, including a restart that
    // re-enters RESET_PLL from RESET_PLL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_RESET_PLL;
            cnt           <= '0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;

            if ((state_nxt != state) || restart_req) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (loss_event && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end

            pll_rst     <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
            sys_reset_n <= (state_nxt == ST_RUN);
            ready       <= (state_nxt == ST_RUN);
            fault       <= (state_nxt == ST_FAULT);
        end
    end

endmodule
